// File: rtl/clock_enable_gen_if.sv
// Configuration and tick bundle for clock_enable_gen. Channel i of div_val sits at [i*CNT_WIDTH +: CNT_WIDTH].
// The master drives divisors and controls. The slave (the generator) drives tick/level/busy.
interface clock_enable_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 26
);
  logic [CHANNELS*CNT_WIDTH-1:0] div_val;
  logic [CHANNELS-1:0]           ch_en;
  logic [CHANNELS-1:0]           mode;
  logic [CHANNELS-1:0]           start;
  logic                          sync;
  logic [CHANNELS-1:0]           tick;
  logic [CHANNELS-1:0]           level;
  logic [CHANNELS-1:0]           busy;

  modport master (
    output div_val, ch_en, mode, start, sync,
    input  tick, level, busy
  );

  modport slave (
    input  div_val, ch_en, mode, start, sync,
    output tick, level, busy
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Per-channel periodic/one-shot tick generator on clk. First periodic tick is D+1 edges after the load edge; one-shot tick is D+1 edges after start.
// No backpressure: ticks are fire-and-forget single-cycle enables, and all outputs are registered.
module clock_enable_gen #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_enable_gen_if.slave  bus
);

  logic [CHANNELS-1:0] tick_v;
  logic [CHANNELS-1:0] level_v;
  logic [CHANNELS-1:0] busy_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 run_q;
    logic                 mode_q;
    logic                 tick_q;
    logic                 level_q;
    logic                 cnt_zero;

    assign d        = bus.div_val[i*CNT_WIDTH +: CNT_WIDTH];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        run_q   <= 1'b0;
        mode_q  <= 1'b0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
      end else if (!bus.ch_en[i]) begin
        // Disabled: counter and level freeze so the LED state is kept.
        run_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (bus.sync) begin
        cnt_q   <= d;
        level_q <= 1'b0;
        tick_q  <= 1'b0;
        if (!mode_q) begin
          run_q <= 1'b1;
        end
      end else if (bus.mode[i] != mode_q) begin
        mode_q <= bus.mode[i];
        run_q  <= 1'b0;
        tick_q <= 1'b0;
        cnt_q  <= d;
      end else if (!mode_q) begin
        if (!run_q) begin
          cnt_q  <= d;
          run_q  <= 1'b1;
          tick_q <= 1'b0;
        end else if (cnt_zero) begin
          tick_q  <= 1'b1;
          level_q <= ~level_q;
          cnt_q   <= d;
        end else begin
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
          tick_q <= 1'b0;
        end
      end else if (bus.start[i]) begin
        // A restart always reloads, but an expiry on the same edge still fires.
        cnt_q <= d;
        run_q <= 1'b1;
        if (run_q && cnt_zero) begin
          tick_q  <= 1'b1;
          level_q <= ~level_q;
        end else begin
          tick_q <= 1'b0;
        end
      end else if (run_q) begin
        if (cnt_zero) begin
          tick_q  <= 1'b1;
          level_q <= ~level_q;
          run_q   <= 1'b0;
        end else begin
          cnt_q  <= cnt_q - CNT_WIDTH'(1);
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick_v[i]  = tick_q;
    assign level_v[i] = level_q;
    assign busy_v[i]  = run_q;
  end

  assign bus.tick  = tick_v;
  assign bus.level = level_v;
  assign bus.busy  = busy_v;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: reset, periodic, one-shot, divisor change, sync and disable.
module tb_clock_enable_gen;
  localparam int CH = 4;
  localparam int W  = 26;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  clock_enable_gen_if #(.CHANNELS(CH), .CNT_WIDTH(W)) bus ();

  clock_enable_gen #(.CHANNELS(CH), .CNT_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.div_val = '0;
    bus.ch_en   = '0;
    bus.mode    = '0;
    bus.start   = '0;
    bus.sync    = 1'b0;
  endtask

  task automatic set_div(input int ch, input logic [W-1:0] d);
    bus.div_val[ch*W +: W] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    total++;
    if ({bus.tick, bus.level, bus.busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state got=%h want=000", {bus.tick, bus.level, bus.busy});
    end
    // Run ch0 with D=5 until it has ticked once (level=1), then reset mid-count.
    set_div(0, 5);
    bus.ch_en[0] = 1'b1;
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      total++;
      if (bus.tick[0] !== (e == 6)) begin
        bad++;
        $display("FAIL reset_pre_tick e=%0d got=%b want=%b", e, bus.tick[0], (e == 6));
      end
    end
    step();
    step();
    rst_n = 1'b0;
    bus.ch_en[0] = 1'b0;
    #1;
    total++;
    if ({bus.tick[0], bus.level[0], bus.busy[0]} !== 3'b000) begin
      bad++;
      $display("FAIL reset_async got=%b want=000", {bus.tick[0], bus.level[0], bus.busy[0]});
    end
    step();
    rst_n = 1'b1;
    step();                 // E0: ch_en still low, channel idle
    bus.ch_en[0] = 1'b1;    // E1 is the load edge, so the first tick lands on E7
    for (int e = 1; e <= 7; e++) begin
      step();
      total++;
      if (bus.tick[0] !== (e == 7)) begin
        bad++;
        $display("FAIL reset_first_tick e=%0d got=%b want=%b", e, bus.tick[0], (e == 7));
      end
    end
  endtask

  task automatic test_periodic();
    do_reset();
    set_div(0, 3);
    set_div(1, 0);
    bus.ch_en = 4'b0011;
    for (int e = 0; e <= 12; e++) begin
      step();
      total++;
      if (bus.tick[0] !== (e > 0 && e % 4 == 0)) begin
        bad++;
        $display("FAIL periodic_tick0 e=%0d got=%b want=%b", e, bus.tick[0], (e > 0 && e % 4 == 0));
      end
      total++;
      if (bus.level[0] !== 1'((e / 4) % 2)) begin
        bad++;
        $display("FAIL periodic_level0 e=%0d got=%b want=%0d", e, bus.level[0], (e / 4) % 2);
      end
      total++;
      if (bus.tick[1] !== (e > 0)) begin
        bad++;
        $display("FAIL periodic_tick1 e=%0d got=%b want=%b", e, bus.tick[1], (e > 0));
      end
      total++;
      if (bus.level[1] !== 1'(e % 2)) begin
        bad++;
        $display("FAIL periodic_level1 e=%0d got=%b want=%0d", e, bus.level[1], e % 2);
      end
      total++;
      if (bus.busy[1:0] !== 2'b11) begin
        bad++;
        $display("FAIL periodic_busy e=%0d got=%b want=11", e, bus.busy[1:0]);
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    set_div(2, 4);
    bus.mode[2]  = 1'b1;
    bus.ch_en[2] = 1'b1;
    step();                 // mode switch reload edge
    total++;
    if (bus.busy[2] !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_idle_busy got=%b want=0", bus.busy[2]);
    end
    bus.start[2] = 1'b1;
    step();                 // S
    bus.start[2] = 1'b0;
    total++;
    if (bus.busy[2] !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_busy_s got=%b want=1", bus.busy[2]);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (bus.tick[2] !== (k == 5)) begin
        bad++;
        $display("FAIL oneshot_tick k=%0d got=%b want=%b", k, bus.tick[2], (k == 5));
      end
      total++;
      if (bus.busy[2] !== (k < 5)) begin
        bad++;
        $display("FAIL oneshot_busy k=%0d got=%b want=%b", k, bus.busy[2], (k < 5));
      end
    end
    total++;
    if (bus.level[2] !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_level got=%b want=1", bus.level[2]);
    end
    // Restart at S+2 pushes the tick out to S+7.
    bus.start[2] = 1'b1;
    step();
    bus.start[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) bus.start[2] = 1'b1;
      step();
      bus.start[2] = 1'b0;
      total++;
      if (bus.tick[2] !== (k == 7)) begin
        bad++;
        $display("FAIL oneshot_restart_tick k=%0d got=%b want=%b", k, bus.tick[2], (k == 7));
      end
      total++;
      if (bus.busy[2] !== (k < 7)) begin
        bad++;
        $display("FAIL oneshot_restart_busy k=%0d got=%b want=%b", k, bus.busy[2], (k < 7));
      end
    end
    total++;
    if (bus.level[2] !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_restart_level got=%b want=0", bus.level[2]);
    end
  endtask

  task automatic test_div_change();
    do_reset();
    set_div(0, 3);
    bus.ch_en[0] = 1'b1;
    step();                 // E0 load
    for (int e = 1; e <= 17; e++) begin
      if (e == 5) set_div(0, 7);
      step();
      total++;
      if (bus.tick[0] !== (e == 4 || e == 8 || e == 16)) begin
        bad++;
        $display("FAIL div_change_tick e=%0d got=%b want=%b", e, bus.tick[0], (e == 4 || e == 8 || e == 16));
      end
    end
  endtask

  task automatic test_sync_disable();
    do_reset();
    set_div(0, 3);
    set_div(1, 3);
    bus.ch_en[0] = 1'b1;
    step();
    step();
    step();
    bus.ch_en[1] = 1'b1;
    step();                 // ch0 at cnt 0 (would tick next), ch1 just loaded
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    total++;
    if ({bus.tick[1:0], bus.level[1:0]} !== 4'b0000) begin
      bad++;
      $display("FAIL sync_edge got=%b want=0000", {bus.tick[1:0], bus.level[1:0]});
    end
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) bus.ch_en[1] = 1'b0;
      step();
      total++;
      if (bus.tick[0] !== (k == 4 || k == 8)) begin
        bad++;
        $display("FAIL sync_tick0 k=%0d got=%b want=%b", k, bus.tick[0], (k == 4 || k == 8));
      end
      total++;
      if (bus.tick[1] !== (k == 4)) begin
        bad++;
        $display("FAIL sync_tick1 k=%0d got=%b want=%b", k, bus.tick[1], (k == 4));
      end
      total++;
      if (bus.level[0] !== (k >= 4 && k < 8)) begin
        bad++;
        $display("FAIL sync_level0 k=%0d got=%b want=%b", k, bus.level[0], (k >= 4 && k < 8));
      end
      total++;
      if (bus.level[1] !== (k >= 4)) begin
        bad++;
        $display("FAIL disable_level1 k=%0d got=%b want=%b", k, bus.level[1], (k >= 4));
      end
      total++;
      if (bus.busy[1] !== (k < 5)) begin
        bad++;
        $display("FAIL disable_busy1 k=%0d got=%b want=%b", k, bus.busy[1], (k < 5));
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_periodic();
    test_oneshot();
    test_div_change();
    test_sync_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
